video_stream_source: RTL
========================

# video_stream_source

AXI4-Stream video master that emits whole frames of 32-bit pixels (tuser on the first pixel of a frame, tlast on the last pixel of each line) from an internal pattern generator. It is the transmitting end of the m_axis_vid stream consumed by the scanout line-buffer block. It stands in for the VDMA during bring-up and bench runs, and it is configured through the same control_op/control_data bus.

## Interface
- LINE_GAP, 0: idle cycles (tvalid low) inserted after each tlast beat; 0 means no gap.
- m_axis_vid_aclk  in  1  sole clock.
- aresetn  in  1  asynchronous active-low reset.
- m_axis_vid_tdata  out  32  pixel, {8'h00, R/G/B bytes per pattern}.
- m_axis_vid_tvalid  out  1  beat valid.
- m_axis_vid_tready  in  1  sink ready.
- m_axis_vid_tlast  out  1  last pixel of a line.
- m_axis_vid_tuser  out  1  first pixel of a frame (x=0, y=0).
- control_op  in  8  opcode, sampled every cycle.
- control_data  in  32  opcode argument.
- frame_count  out  16  frames completed; wraps at 16'hFFFF→0.
- dbg_state  out  8  {5'b0, state[2:0]}.

## Operation
- Control bus is registered once (op_in/data_in); decode acts on the registered copy. Opcodes:
  - 2 OP_DIMENSIONS: height=[31:16], width=[15:0]; reset 720/1280.
  - 10 OP_PATTERN: pattern=[1:0]; reset 0.
  - 11 OP_ENABLE: enable=[0]; reset 0.
  - 12 OP_COLOR: color=[23:0]; reset 0.
  - All other opcodes are ignored.
- Width, height and pattern are shadowed into active registers in LOAD only. A change made mid-frame takes effect at the next frame.
- States:
  - IDLE(0): tvalid=0. Moves to LOAD when enable=1.
  - LOAD(1): copies shadows, x=0, y=0. Moves to STREAM; if shadow width or height is 0, moves back to IDLE instead and emits no beats.
  - STREAM(2): drives the beat at (x,y). On a handshake (tvalid&&tready):
    - x<w-1: x++.
    - x=w-1 and y<h-1: x=0, y++, then GAP, or STREAM when LINE_GAP=0.
    - x=w-1 and y=h-1: goes to FEND.
  - GAP(3): counts LINE_GAP cycles with tvalid=0, then returns to STREAM.
  - FEND(4): frame_count++. Goes to LOAD if enable, else IDLE.
- Beat fields:
  - tuser = (x==0 && y==0).
  - tlast = (x==w-1).
  - Both are valid together with tdata.
- Patterns (x, y are the 16-bit counters):
  - 0 solid: {8'h00, color}.
  - 1 gradient: {8'h00, x[7:0], x[7:0], x[7:0]}.
  - 2 checker: (x[3]^y[3]) ? 32'h00FFFFFF : 32'h0.
  - 3 counter: {8'h00, frame_count[7:0], y[7:0], x[7:0]}.
- Clearing enable mid-frame does not truncate the frame. The frame completes, then FEND goes to IDLE.
- A single-pixel frame (w=1, h=1) is one beat with tuser=1 and tlast=1.

## Timing
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0, frame_count=0, dbg_state=0, state IDLE. Reset applies immediately, including mid-beat; no partial frame is resumed.
- All outputs are registered; no combinational path from tready to any output.
- AXI rule: while tvalid=1 and tready=0, tdata/tlast/tuser/tvalid hold stable. tvalid never drops without a handshake.
- Enable latency: OP_ENABLE on control_op at edge N → op_in at N+1 → enable=1 at N+2 → LOAD at N+3 → first beat (tvalid=1, tuser=1) visible after edge N+4.
- Throughput: with tready held high and LINE_GAP=0, one beat per cycle within a frame. Between frames there is a 2-cycle bubble (FEND, LOAD).
- Line period is w + LINE_GAP cycles with tready high. The GAP count starts the cycle after the tlast handshake.
- frame_count updates one cycle after the final (tlast, y=h-1) handshake.

## Test plan
- After reset: outputs 0 and dbg_state=0. Write OP_DIMENSIONS=0x0002_0004, OP_PATTERN=1, OP_ENABLE=1 with tready=1. Expected:
  - First tvalid exactly at the N+4 edge.
  - 8 beats: tdata x-gradient 0,0x010101,0x020202,0x030303 per line.
  - tuser only on beat 0; tlast on beats 3 and 7.
  - frame_count=1.
- Backpressure: random tready (50%), 3x2 pattern 3. Expected: no tdata/tuser/tlast change while stalled; exactly 6 handshakes per frame with the correct {frame,y,x} values.
- LINE_GAP=2, 4x3 frame, tready=1. Expected: tvalid low for exactly 2 cycles after each non-final tlast; total frame length 4*3+2*2 cycles.
- Clear enable at pixel (1,1) of a 4x4 frame, and write OP_DIMENSIONS mid-frame. Expected: the frame completes all 16 beats at the old size, then IDLE with frame_count incremented by 1.
- Zero and one sizes. Expected:
  - Width=0: no beats; state oscillates IDLE/LOAD while enabled.
  - 1x1 solid color=0x123456: every beat is 0x00123456 with tuser=tlast=1.
- Assert aresetn low mid-line with tvalid=1. Expected: tvalid=0 immediately. After release with enable re-written, the next frame starts with tuser at (0,0).

Source files
------------

// File: rtl/video_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : video_stream_source
// Description : AXI4-Stream video master. Emits whole frames of 32-bit pixels
//               from an internal pattern generator. tuser marks the first
//               pixel of a frame and tlast marks the last pixel of each line.
//               Configured through the control_op/control_data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module video_stream_source #(
   parameter int LINE_GAP = 0
) (
   input  logic        m_axis_vid_aclk,
   input  logic        aresetn,
   output logic [31:0] m_axis_vid_tdata,
   output logic        m_axis_vid_tvalid,
   input  logic        m_axis_vid_tready,
   output logic        m_axis_vid_tlast,
   output logic        m_axis_vid_tuser,
   input  logic [7:0]  control_op,
   input  logic [31:0] control_data,
   output logic [15:0] frame_count,
   output logic [7:0]  dbg_state
);

   // Control opcodes
   localparam logic [7:0]  c_op_dimensions = 8'd2;
   localparam logic [7:0]  c_op_pattern    = 8'd10;
   localparam logic [7:0]  c_op_enable     = 8'd11;
   localparam logic [7:0]  c_op_color      = 8'd12;

   // Frame sequencer states
   localparam logic [2:0]  c_st_idle   = 3'd0;
   localparam logic [2:0]  c_st_load   = 3'd1;
   localparam logic [2:0]  c_st_stream = 3'd2;
   localparam logic [2:0]  c_st_gap    = 3'd3;
   localparam logic [2:0]  c_st_fend   = 3'd4;

   // Reset geometry (1280x720)
   localparam logic [15:0] c_width_rst  = 16'd1280;
   localparam logic [15:0] c_height_rst = 16'd720;

   // GAP counts down from LINE_GAP-1 to 0, so it lasts exactly LINE_GAP cycles
   localparam logic [15:0] c_gap_last = (LINE_GAP > 0) ? 16'(LINE_GAP - 1) : 16'd0;

   // Registered control bus
   logic [7:0]  r_op_in;
   logic [31:0] r_data_in;

   // Shadow (programmed) configuration
   logic [15:0] r_width_sh;
   logic [15:0] r_height_sh;
   logic [1:0]  r_pattern_sh;
   logic        r_enable;
   logic [23:0] r_color;

   // Active frame state
   logic [2:0]  r_state;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic [15:0] r_w;
   logic [15:0] r_h;
   logic [1:0]  r_pat;
   logic [15:0] r_gap_cnt;
   logic [15:0] r_frame_count;

   // Registered stream outputs
   logic        r_tvalid;
   logic [31:0] r_tdata;
   logic        r_tlast;
   logic        r_tuser;

   // Next-state values
   logic [2:0]  w_state_nxt;
   logic [15:0] w_x_nxt;
   logic [15:0] w_y_nxt;
   logic [15:0] w_w_nxt;
   logic [15:0] w_h_nxt;
   logic [1:0]  w_pat_nxt;
   logic [15:0] w_gap_nxt;
   logic [15:0] w_fc_nxt;
   logic        w_load_beat;
   logic        w_drop_beat;

   // Helpers
   logic        w_handshake;
   logic        w_x_last;
   logic        w_y_last;
   logic        w_size_zero;
   logic [31:0] w_beat_data;
   logic        w_beat_user;
   logic        w_beat_last;

   // Pixel value for a position under the given pattern
   function automatic logic [31:0] f_pixel(
      input logic [1:0]  pat,
      input logic [7:0]  x,
      input logic [7:0]  y,
      input logic [23:0] color,
      input logic [7:0]  fc
   );
      logic [31:0] v;
      case (pat)
         2'd0:    v = {8'h00, color};
         2'd1:    v = {8'h00, x, x, x};
         2'd2:    v = (x[3] ^ y[3]) ? 32'h00FF_FFFF : 32'h0000_0000;
         default: v = {8'h00, fc, y, x};
      endcase
      return v;
   endfunction

   // Register the control bus once; decode works from this copy only
   always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_op_in   <= 8'd0;
         r_data_in <= 32'd0;
      end else begin
         r_op_in   <= control_op;
         r_data_in <= control_data;
      end
   end

   // Opcode decode into shadow configuration registers
   always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_width_sh   <= c_width_rst;
         r_height_sh  <= c_height_rst;
         r_pattern_sh <= 2'd0;
         r_enable     <= 1'b0;
         r_color      <= 24'd0;
      end else begin
         case (r_op_in)
            c_op_dimensions: begin
               r_height_sh <= r_data_in[31:16];
               r_width_sh  <= r_data_in[15:0];
            end
            c_op_pattern: r_pattern_sh <= r_data_in[1:0];
            c_op_enable:  r_enable     <= r_data_in[0];
            c_op_color:   r_color      <= r_data_in[23:0];
            default:      ;
         endcase
      end
   end

   // Position and handshake qualifiers for the beat currently on the bus
   always_comb begin
      w_handshake = r_tvalid && m_axis_vid_tready;
      w_x_last    = (r_x == r_w - 16'd1);
      w_y_last    = (r_y == r_h - 16'd1);
      w_size_zero = (r_width_sh == 16'd0) || (r_height_sh == 16'd0);
   end

   // Frame sequencer: next state, next position, and whether a beat is issued
   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_w_nxt     = r_w;
      w_h_nxt     = r_h;
      w_pat_nxt   = r_pat;
      w_gap_nxt   = r_gap_cnt;
      w_fc_nxt    = r_frame_count;
      w_load_beat = 1'b0;
      w_drop_beat = 1'b0;
      case (r_state)
         c_st_idle: begin
            if (r_enable) begin
               w_state_nxt = c_st_load;
            end
         end
         c_st_load: begin
            // Geometry and pattern are latched here only, so mid-frame
            // writes never disturb the frame in flight.
            w_w_nxt   = r_width_sh;
            w_h_nxt   = r_height_sh;
            w_pat_nxt = r_pattern_sh;
            w_x_nxt   = 16'd0;
            w_y_nxt   = 16'd0;
            if (w_size_zero) begin
               w_state_nxt = c_st_idle;
            end else begin
               w_state_nxt = c_st_stream;
               w_load_beat = 1'b1;
            end
         end
         c_st_stream: begin
            if (w_handshake) begin
               if (!w_x_last) begin
                  w_x_nxt     = r_x + 16'd1;
                  w_load_beat = 1'b1;
               end else if (!w_y_last) begin
                  w_x_nxt = 16'd0;
                  w_y_nxt = r_y + 16'd1;
                  if (LINE_GAP == 0) begin
                     w_load_beat = 1'b1;
                  end else begin
                     w_state_nxt = c_st_gap;
                     w_gap_nxt   = c_gap_last;
                     w_drop_beat = 1'b1;
                  end
               end else begin
                  w_state_nxt = c_st_fend;
                  w_drop_beat = 1'b1;
               end
            end
         end
         c_st_gap: begin
            // Position was already advanced on the tlast handshake
            if (r_gap_cnt == 16'd0) begin
               w_state_nxt = c_st_stream;
               w_load_beat = 1'b1;
            end else begin
               w_gap_nxt = r_gap_cnt - 16'd1;
            end
         end
         c_st_fend: begin
            w_fc_nxt    = r_frame_count + 16'd1;
            w_state_nxt = r_enable ? c_st_load : c_st_idle;
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   // Beat fields for the position the sequencer moves to
   always_comb begin
      w_beat_data = f_pixel(w_pat_nxt, w_x_nxt[7:0], w_y_nxt[7:0],
                            r_color, r_frame_count[7:0]);
      w_beat_user = (w_x_nxt == 16'd0) && (w_y_nxt == 16'd0);
      w_beat_last = (w_x_nxt == w_w_nxt - 16'd1);
   end

   // Sequencer state registers
   always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state       <= c_st_idle;
         r_x           <= 16'd0;
         r_y           <= 16'd0;
         r_w           <= 16'd0;
         r_h           <= 16'd0;
         r_pat         <= 2'd0;
         r_gap_cnt     <= 16'd0;
         r_frame_count <= 16'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_x           <= w_x_nxt;
         r_y           <= w_y_nxt;
         r_w           <= w_w_nxt;
         r_h           <= w_h_nxt;
         r_pat         <= w_pat_nxt;
         r_gap_cnt     <= w_gap_nxt;
         r_frame_count <= w_fc_nxt;
      end
   end

   // Output beat register; only changes on a new beat or when the bus goes idle,
   // so a stalled beat stays stable until accepted
   always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_tvalid <= 1'b0;
         r_tdata  <= 32'd0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end else if (w_load_beat) begin
         r_tvalid <= 1'b1;
         r_tdata  <= w_beat_data;
         r_tlast  <= w_beat_last;
         r_tuser  <= w_beat_user;
      end else if (w_drop_beat) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
      end
   end

   assign m_axis_vid_tdata  = r_tdata;
   assign m_axis_vid_tvalid = r_tvalid;
   assign m_axis_vid_tlast  = r_tlast;
   assign m_axis_vid_tuser  = r_tuser;
   assign frame_count       = r_frame_count;
   assign dbg_state         = {5'b00000, r_state};

endmodule
`default_nettype wire
